// File: rtl/cordic_sched.sv
// Shared iterative CORDIC cosine engine: round-robin arbitration over NREQ requesters,
// one micro-rotation per clock, result returned on a valid/ready channel tagged with the requester ID.
//
// state | meaning
// IDLE  | waiting for a request; combinational round-robin grant
// ROT   | one micro-rotation per cycle, step 0..ITER-1
// DONE  | result held on the response channel until rsp_ready
module cordic_sched #(
  parameter int NREQ = 4,
  parameter int ITER = 15,
  parameter int IDW  = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [32*NREQ-1:0]     i_req_angle,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [31:0]            o_rsp_cosine,
  output logic [IDW-1:0]         o_rsp_id,
  output logic                   o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;

  state_t             r_state;
  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic [32:0]        r_z;
  logic [3:0]         r_step;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_rsp_id;
  logic [31:0]        r_rsp_cosine;

  state_t             w_nxt_state;
  logic signed [31:0] w_nxt_x;
  logic signed [31:0] w_nxt_y;
  logic [32:0]        w_nxt_z;
  logic [3:0]         w_nxt_step;
  logic [IDW-1:0]     w_nxt_rr_ptr;
  logic [IDW-1:0]     w_nxt_rsp_id;
  logic [31:0]        w_nxt_rsp_cosine;

  logic [IDW-1:0]     w_grant;
  logic               w_grant_vld;
  logic [31:0]        w_grant_angle;

  logic               w_zs;
  logic signed [31:0] w_xs;
  logic signed [31:0] w_ys;
  logic [15:0]        w_atan;
  logic [32:0]        w_atan_ext;
  logic signed [31:0] w_x_rot;
  logic signed [31:0] w_y_rot;
  logic [32:0]        w_z_rot;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'hc910;
      4'd1:    atan_lut = 16'h76b2;
      4'd2:    atan_lut = 16'h3eb7;
      4'd3:    atan_lut = 16'h1fd6;
      4'd4:    atan_lut = 16'h0ffb;
      4'd5:    atan_lut = 16'h07ff;
      4'd6:    atan_lut = 16'h0400;
      4'd7:    atan_lut = 16'h0200;
      4'd8:    atan_lut = 16'h0100;
      4'd9:    atan_lut = 16'h0080;
      4'd10:   atan_lut = 16'h0040;
      4'd11:   atan_lut = 16'h0020;
      4'd12:   atan_lut = 16'h0010;
      4'd13:   atan_lut = 16'h0008;
      4'd14:   atan_lut = 16'h0004;
      default: atan_lut = 16'h0002;
    endcase
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    logic [IDW:0] idx;
    w_grant     = '0;
    w_grant_vld = 1'b0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!w_grant_vld && i_req_valid[idx[IDW-1:0]]) begin
        w_grant     = idx[IDW-1:0];
        w_grant_vld = 1'b1;
      end
    end
  end

  assign w_grant_angle = i_req_angle[32*int'(w_grant) +: 32];

  // Zero angle is steered down the negative path, matching the unrolled unit.
  assign w_zs       = r_z[32] | (r_z == 33'd0);
  assign w_xs       = r_x >>> r_step;
  assign w_ys       = r_y >>> r_step;
  assign w_atan     = atan_lut(r_step);
  assign w_atan_ext = {{17{w_atan[15]}}, w_atan};
  assign w_x_rot    = w_zs ? (r_x + w_ys) : (r_x - w_ys);
  assign w_y_rot    = w_zs ? (r_y - w_xs) : (r_y + w_xs);
  assign w_z_rot    = w_zs ? (r_z + w_atan_ext) : (r_z - w_atan_ext);

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_x          = r_x;
    w_nxt_y          = r_y;
    w_nxt_z          = r_z;
    w_nxt_step       = r_step;
    w_nxt_rr_ptr     = r_rr_ptr;
    w_nxt_rsp_id     = r_rsp_id;
    w_nxt_rsp_cosine = r_rsp_cosine;
    o_req_ready      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          o_req_ready  = {{(NREQ-1){1'b0}}, 1'b1} << w_grant;
          w_nxt_x      = 32'sd65536;
          w_nxt_y      = '0;
          w_nxt_z      = {1'b0, w_grant_angle};
          w_nxt_step   = '0;
          w_nxt_rsp_id = w_grant;
          w_nxt_rr_ptr = (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + 1'b1;
          w_nxt_state  = S_ROT;
        end
      end
      S_ROT: begin
        w_nxt_x    = w_x_rot;
        w_nxt_y    = w_y_rot;
        w_nxt_z    = w_z_rot;
        w_nxt_step = r_step + 4'd1;
        if (r_step == 4'(ITER-1)) begin
          w_nxt_rsp_cosine = w_x_rot;
          w_nxt_state      = S_DONE;
        end
      end
      S_DONE: begin
        if (i_rsp_ready) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_step       <= '0;
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_rsp_cosine <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_x          <= w_nxt_x;
      r_y          <= w_nxt_y;
      r_z          <= w_nxt_z;
      r_step       <= w_nxt_step;
      r_rr_ptr     <= w_nxt_rr_ptr;
      r_rsp_id     <= w_nxt_rsp_id;
      r_rsp_cosine <= w_nxt_rsp_cosine;
    end
  end

  assign o_rsp_valid  = (r_state == S_DONE);
  assign o_busy       = (r_state == S_ROT) || (r_state == S_DONE);
  assign o_rsp_cosine = r_rsp_cosine;
  assign o_rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched: expected responses are queued at acceptance
// and compared against the response channel when it fires.
module tb_cordic_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_angle;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_cosine;
  logic [1:0]   rsp_id;
  logic         busy;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] cos;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] atan_t [0:15] = '{16'hc910, 16'h76b2, 16'h3eb7, 16'h1fd6, 16'h0ffb, 16'h07ff,
                                 16'h0400, 16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020,
                                 16'h0010, 16'h0008, 16'h0004, 16'h0002};

  cordic_sched #(.NREQ(4), .ITER(15), .IDW(2)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .i_req_angle  (req_angle),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_cosine (rsp_cosine),
    .o_rsp_id     (rsp_id),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: the 15-stage unrolled cosine datapath.
  function automatic logic [31:0] golden(input logic [31:0] ang);
    logic signed [31:0] x, y, xs, ys;
    logic [32:0] z, a;
    x = 32'sd65536;
    y = 32'sd0;
    z = {1'b0, ang};
    for (int i = 0; i < 15; i++) begin
      a  = {{17{atan_t[i][15]}}, atan_t[i]};
      xs = x >>> i;
      ys = y >>> i;
      if (z[32] || z == 33'd0) begin
        x = x + ys; y = y - xs; z = z + a;
      end else begin
        x = x - ys; y = y + xs; z = z - a;
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    n_checks++;
    assert (sb.size() != 0) n_pass++;
    else $error("FAIL sb_empty: observed response id %0d, expected no response", rsp_id);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_cosine", {32'd0, rsp_cosine}, {32'd0, e.cos});
      chk("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Called at 1 time unit after an edge with the DUT idle; returns likewise, idle again.
  task automatic do_req(input int k, input logic [31:0] ang);
    int cyc;
    rsp_ready = 1'b1;
    req_angle[32*k +: 32] = ang;
    req_valid = 4'b0001 << k;
    #1;
    chk("grant", {60'd0, req_ready}, {60'd0, 4'b0001 << k});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk("busy", {63'd0, busy}, 64'd1);
    chk("ready_in_rot", {60'd0, req_ready}, 64'd0);
    sb.push_back('{2'(k), golden(ang)});
    wait_rsp(cyc);
    chk("latency", 64'(cyc), 64'd15);
    check_rsp();
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, acc, last, g, cnt;
    exp_t e;
    logic [31:0] specials [5];
    logic [31:0] ang4 [4];
    specials = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
    ang4     = '{32'h1234_5678, 32'h0, 32'h9abc_def0, 32'h2000_0000};

    rst_n = 1'b0; req_valid = '0; req_angle = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_cosine", {32'd0, rsp_cosine}, 64'd0);
    chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, angle zero, requester 0.
    do_req(0, 32'h0);

    // Angle sweep on requester 2.
    for (int i = 0; i < 1000; i++)
      do_req(2, (i < 5) ? specials[i] : $urandom);

    // Fairness with all requesters held valid, from a fresh pointer.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_angle = {ang4[3], ang4[2], ang4[1], ang4[0]};
    rsp_ready = 1'b1;
    req_valid = 4'hf;
    acc = 0; last = 0; cyc = 0;
    while ((acc < 5 || sb.size() != 0) && cyc < 300) begin
      #1;
      chk("onehot0", {63'd0, $onehot0(req_ready)}, 64'd1);
      if (req_ready != 4'b0000) begin
        g = 0;
        for (int b = 0; b < 4; b++) if (req_ready[b]) g = b;
        chk("rr_order", 64'(g), 64'(acc % 4));
        if (acc > 0) chk("accept_spacing", 64'(cyc - last), 64'd17);
        last = cyc;
        sb.push_back('{2'(g), golden(ang4[g])});
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc == 5) req_valid = 4'b0000;
      if (rsp_valid) check_rsp();
    end
    chk("fair_accepts", 64'(acc), 64'd5);
    @(posedge clk); #1;

    // Back-pressure in DONE; requester 3 waits meanwhile.
    rsp_ready = 1'b0;
    req_angle[63:32]  = 32'h4000_0000;
    req_angle[127:96] = 32'h0f0f_0f0f;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant1", {60'd0, req_ready}, 64'h2);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    sb.push_back('{2'd1, golden(32'h4000_0000)});
    wait_rsp(cyc);
    chk("bp_latency", 64'(cyc), 64'd15);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_cosine", {32'd0, rsp_cosine}, {32'd0, e.cos});
      chk("bp_id", {62'd0, rsp_id}, 64'd1);
      chk("bp_ready0", {60'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    check_rsp();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    chk("bp_next_grant", {60'd0, req_ready}, 64'h8);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    sb.push_back('{2'd3, golden(32'h0f0f_0f0f)});
    rsp_ready = 1'b1;
    wait_rsp(cyc);
    check_rsp();
    @(posedge clk); #1;

    // Reset at step 7 of a computation on requester 2.
    req_angle[95:64] = 32'h3333_3333;
    req_valid = 4'b0100;
    #1;
    chk("abort_grant", {60'd0, req_ready}, 64'h4);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_cosine", {32'd0, rsp_cosine}, 64'd0);
    chk("abort_id", {62'd0, rsp_id}, 64'd0);
    req_valid = 4'hf;
    #1;
    chk("abort_rr_ptr0", {60'd0, req_ready}, 64'h1);
    req_valid = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("abort_no_rsp", 64'(cnt), 64'd0);

    // Requester 1 pulses valid only while another request is rotating.
    rsp_ready = 1'b1;
    req_angle[95:64] = 32'h0800_0000;
    req_valid = 4'b0100;
    #1;
    chk("late_grant2", {60'd0, req_ready}, 64'h4);
    @(posedge clk); #1;
    sb.push_back('{2'd2, golden(32'h0800_0000)});
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      chk("late_ready0", {60'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    wait_rsp(cyc);
    check_rsp();
    @(posedge clk); #1;
    req_valid = 4'hf;
    #1;
    chk("late_ptr", {60'd0, req_ready}, 64'h8);
    req_valid = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("late_no_rsp", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Iterative cosine engine shared by NREQ requesters.
- Round-robin arbitration picks one request at a time.
- One CORDIC micro-rotation runs per clock, ITER steps total, using arithmetic bit-identical to the team's unrolled 15-stage combinational cosine unit.
- Replaces the unrolled unit where area matters; the result is returned on a valid/ready response channel tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..16).
- ITER, 15, number of micro-rotations; must be ≤16 (size of the atan table).
- IDW, 2, width of rsp_id; must equal clog2(NREQ).

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_angle  in  32*NREQ  per-requester angle; requester k occupies bits [32k+31:32k].
- req_ready  out  NREQ  one-hot accept; at most one bit is high.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_cosine  out  32  signed result (final x).
- rsp_id  out  IDW  index of the requester that is being served.
- busy  out  1  high in ROT and DONE.

Behaviour:
- Reset values (reset_n=0 sampled at a clock edge):
  - State goes to IDLE; rsp_valid=0, rsp_cosine=0, rsp_id=0, busy=0, req_ready=0.
  - rr_ptr=0; x/y/z/step registers are cleared.
- Reset mid-operation: the in-flight computation is aborted silently and no response is produced.
- State machine: IDLE -> ROT -> DONE -> IDLE.
- IDLE:
  - Grant is combinational: the first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[grant]=1 in the same cycle. The grant is not sticky and is recomputed every IDLE cycle.
  - On acceptance (req_valid&req_ready):
    - x=65536, y=0;
    - z = {1'b0, angle}, i.e. 33 bits, zero-extended;
    - step=0, rsp_id=grant, rr_ptr=(grant+1) mod NREQ;
    - next state ROT.
  - With no valid request, remain in IDLE.
- ROT: one iteration per cycle with i = step.
  - zs = z[32] | (z==0).
  - xs = x>>>i, ys = y>>>i (arithmetic shift, 32-bit signed).
  - x' = zs ? x+ys : x-ys.
  - y' = zs ? y-xs : y+xs.
  - z' = zs ? z+atan[i] : z-atan[i], with atan[i] sign-extended from 16 to 33 bits. All sums wrap modulo 2^32 (x, y) or 2^33 (z).
  - atan[0..15] = c910, 76b2, 3eb7, 1fd6, 0ffb, 07ff, 0400, 0200, 0100, 0080, 0040, 0020, 0010, 0008, 0004, 0002 (hex). Entry 0 is negative as a signed value and is used as-is.
  - step increments each cycle. When the step==ITER-1 iteration completes, rsp_cosine=x' and the state moves to DONE.
- DONE:
  - rsp_valid=1; rsp_cosine and rsp_id stay stable until rsp_ready=1.
  - On the handshake, rsp_valid drops the next cycle and the state returns to IDLE.
  - No request is accepted in DONE or ROT (req_ready=0).
- Timing:
  - Acceptance at edge T gives rsp_valid=1 from edge T+ITER onward.
  - Minimum spacing between acceptances is ITER+2 cycles (with rsp_ready held high).
- Requester rules:
  - Requesters must hold req_valid and req_angle until accepted.
  - If req_valid drops before acceptance, that requester simply loses the grant; no error is raised.
- Boundaries:
  - angle=0 takes the zs=1 path at i=0 (zero counts as negative).
  - angle ≥ 2^31 is still treated as positive, because of zero-extension into 33 bits.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… and each requester waits at most NREQ-1 services.

Test Plan:
- Reset, then req_valid=4'b0001 with angle=0:
  - req_ready=0001 in the same cycle; busy=1 from the next cycle.
  - rsp_valid rises exactly 15 cycles after acceptance, rsp_id=0.
  - rsp_cosine equals the bit-exact golden model (15-stage unrolled cosine).
- Random sweep of 1000 angles, including 0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF, on requester 2: every rsp_cosine matches the golden model bit-for-bit and rsp_id=2.
- req_valid=4'b1111 held, rsp_ready=1: accepted order is 0,1,2,3,0; acceptances are 17 cycles apart; req_ready is always one-hot or zero.
- rsp_ready held low for 10 cycles in DONE: rsp_valid, rsp_cosine and rsp_id stay stable, req_ready=0 throughout; one cycle after rsp_ready=1, the next request is granted.
- reset_n=0 for one cycle at step 7 of a computation: the next cycle shows IDLE, rsp_valid=0, busy=0, rr_ptr=0, and no response ever appears for the aborted request.
- Requester 1 asserts req_valid while another request is in ROT, then deasserts before IDLE: no grant is given to 1 and the pointer is unchanged by it.
